mult_sweep_checker: RTL and testbench
=====================================

Name: mult_sweep_checker

Overview:
- Exhaustive operand sweep engine and error accumulator for the generated multipliers in this codebase.
- Feeds every (A,B) pair to one combinational or pipelined multiplier under test and consumes its product P.
- Compares each P against the exact A*B and accumulates error statistics for ranking candidate architectures.
- Sits directly around the multiplier under test: op_a/op_b drive its A/B inputs, and its P output returns on prod_in.

Parameters:
- W, 8, operand width of the multiplier under test; product width is 2W.
- LAT, 0, clock edges from op_a/op_b change until the matching prod_in is valid. 0 means combinational.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a new sweep; single-cycle pulse
- abort  in  1  stop the sweep and return to IDLE
- op_a  out  W  operand A to the multiplier under test
- op_b  out  W  operand B to the multiplier under test
- prod_in  in  2W  product returned by the multiplier under test
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE; the statistics are final
- err_count  out  2W+1  number of vectors with prod_in != A*B
- max_err  out  2W  largest |prod_in - A*B| seen
- sum_err  out  4W  sum of |prod_in - A*B| over all vectors
- first_err_valid  out  1  at least one mismatch was recorded
- first_err_a  out  W  op_a of the first mismatching vector
- first_err_b  out  W  op_b of the first mismatching vector

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - Every output is 0, including op_a, op_b, all statistics and first_err_*.
  - The index counter and the delay line are cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE or DONE with start=1:
  - Clear all statistics, first_err_*, the index and the delay line.
  - Go to RUN.
- RUN:
  - A 2W-bit index increments by 1 every cycle; op_a = idx[W-1:0], op_b = idx[2W-1:W].
  - The first vector (0,0) is driven in the cycle after the start edge.
  - At the edge that issues the last vector (all ones), go to DRAIN.
  - The index wraps to 0 and op_a/op_b hold at 0 after the sweep.
- Delay line:
  - A LAT-deep shift register carries (a, b, issue_valid) alongside the multiplier.
  - prod_in is sampled at the edge where the delayed issue_valid is 1.
- Pipeline, from the sample edge:
  - Stage C registers a, b, exact=a*b (2W bits) and abs=|prod_in-exact| (2W bits, unsigned).
  - Stage S, one edge later, updates the statistics:
    - err_count += (abs!=0)
    - max_err = max(max_err, abs)
    - sum_err += abs
    - If abs!=0 and first_err_valid=0: latch a, b and set first_err_valid.
- DRAIN:
  - Lasts exactly LAT+2 cycles, then go to DONE.
  - done rises 2^(2W)+LAT+2 edges after the start edge.
- DONE:
  - done=1, busy=0; the statistics hold until the next start.
- start while busy=1 is ignored.
- abort=1 in RUN or DRAIN:
  - Go to IDLE next edge and flush the delay line and stage valids.
  - Statistics freeze at their current values; done stays 0.
- abort has priority over start in the same cycle. abort in IDLE or DONE has no effect.
- Width rules:
  - abs ≤ 2^(2W)-1, so 2^(2W) vectors give sum_err < 2^(4W). sum_err never overflows.
  - err_count needs 2W+1 bits to hold 2^(2W).
- Reset mid-sweep: immediate return to the full reset state; no partial results are retained.

Decomposition:
- Shared package (mult_sweep_pkg):
  - state enum {IDLE, RUN, DRAIN, DONE}
  - default width constants W=8, PW=2W
  - helper function returning the drain length LAT+2
- One natural sub-module: mult_err_stage. It takes a, b, prod and a valid in, and produces the registered exact product, abs error and valid (stage C).
- The FSM, index counter, delay line and accumulators stay in the top level.

Test Plan:
- Exact model (P=A*B), W=8, LAT=0, pulse start:
  - busy for 65538 cycles, then done=1.
  - err_count=0, max_err=0, sum_err=0, first_err_valid=0.
- Model P=(A*B)|1, W=8, LAT=0:
  - err_count=49152, max_err=1, sum_err=49152.
  - first_err_valid=1 with first_err_a=0, first_err_b=0.
- Model P=0, W=2, LAT=0:
  - err_count=9, max_err=9, sum_err=36.
  - first_err=(1,1); done 18 cycles after start.
- Exact model registered 2 stages, W=8, LAT=2:
  - zero errors; done exactly 65540 cycles after start.
- Model P=0, W=8:
  - abort at cycle 100 → IDLE next edge, busy=0, done=0, statistics frozen.
  - start again → statistics cleared, full sweep completes normally.
  - start pulsed mid-run → ignored, and the final counts equal those of an undisturbed run.
- Reset mid-sweep:
  - rst_n low at cycle 500 → all outputs 0 asynchronously.
  - After release, start → correct complete sweep.

Source files
------------

// File: rtl/mult_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_sweep_pkg
// Brief    : Shared types and constants for the multiplier sweep checker.
// Revision : 1.0
// ============================================================================
package mult_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_t;

    localparam int c_DEF_W  = 8;
    localparam int c_DEF_PW = 2 * c_DEF_W;

    // Cycles spent in DRAIN: LAT for the multiplier, one for stage C, one for stage S.
    function automatic int drain_len(input int lat);
        return lat + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_err_stage.sv
`default_nettype none
// ============================================================================
// Module   : mult_err_stage
// Brief    : Registers operands and absolute product error of one sampled vector.
// Revision : 1.0
// ============================================================================
module mult_err_stage #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [2*W-1:0]   prod,
    output logic             out_valid,
    output logic [W-1:0]     out_a,
    output logic [W-1:0]     out_b,
    output logic [2*W-1:0]   abs_err
);

    logic [2*W-1:0] w_exact;
    logic [2*W-1:0] w_abs;

    always_comb begin
        w_exact = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        w_abs   = (prod >= w_exact) ? (prod - w_exact) : (w_exact - prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            abs_err   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            abs_err   <= '0;
        end else begin
            out_valid <= in_valid;
            out_a     <= a;
            out_b     <= b;
            abs_err   <= w_abs;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : mult_sweep_checker
// Brief    : Exhaustive operand sweep of a multiplier with error accumulation.
// Revision : 1.0
// ============================================================================
module mult_sweep_checker
    import mult_sweep_pkg::*;
#(
    parameter int W   = c_DEF_W,
    parameter int LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic [2*W-1:0]   prod_in,
    output logic             busy,
    output logic             done,
    output logic [2*W:0]     err_count,
    output logic [2*W-1:0]   max_err,
    output logic [4*W-1:0]   sum_err,
    output logic             first_err_valid,
    output logic [W-1:0]     first_err_a,
    output logic [W-1:0]     first_err_b
);

    localparam int                c_PW         = 2 * W;
    localparam int                c_DRAIN_CYC  = drain_len(LAT);
    localparam int                c_DCW        = $clog2(c_DRAIN_CYC);
    localparam logic [c_DCW-1:0]  c_DRAIN_LAST = c_DCW'(c_DRAIN_CYC - 1);

    sweep_state_t      r_state;
    sweep_state_t      w_state_nxt;
    logic [c_PW-1:0]   r_idx;
    logic [c_DCW-1:0]  r_drain_cnt;
    logic              w_start_go;
    logic              w_flush;
    logic              w_issue;

    logic [W-1:0]      w_dl_a;
    logic [W-1:0]      w_dl_b;
    logic              w_dl_v;

    logic              w_c_valid;
    logic [W-1:0]      w_c_a;
    logic [W-1:0]      w_c_b;
    logic [c_PW-1:0]   w_c_abs;
    logic              w_c_mism;

    // abort outranks start, so a simultaneous pair never launches a sweep
    assign w_start_go = start && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_flush    = w_start_go || (abort && busy);
    assign w_issue    = (r_state == ST_RUN);
    assign op_a       = r_idx[W-1:0];
    assign op_b       = r_idx[c_PW-1:W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_go) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (abort)             w_state_nxt = ST_IDLE;
                else if (r_idx == '1)  w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (abort)                             w_state_nxt = ST_IDLE;
                else if (r_drain_cnt == c_DRAIN_LAST)  w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (w_start_go) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_drain_cnt <= '0;
        end else if (w_flush) begin
            r_idx       <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (r_state == ST_RUN) r_idx <= r_idx + 1'b1;
            if (r_state == ST_DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
            else                     r_drain_cnt <= '0;
        end
    end

    generate
        if (LAT == 0) begin : g_no_delay
            assign w_dl_a = r_idx[W-1:0];
            assign w_dl_b = r_idx[c_PW-1:W];
            assign w_dl_v = w_issue;
        end else begin : g_delay
            logic [W-1:0] r_dl_a [0:LAT-1];
            logic [W-1:0] r_dl_b [0:LAT-1];
            logic         r_dl_v [0:LAT-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) begin
                        r_dl_a[i] <= '0;
                        r_dl_b[i] <= '0;
                        r_dl_v[i] <= 1'b0;
                    end
                end else if (w_flush) begin
                    for (int i = 0; i < LAT; i++) begin
                        r_dl_a[i] <= '0;
                        r_dl_b[i] <= '0;
                        r_dl_v[i] <= 1'b0;
                    end
                end else begin
                    r_dl_a[0] <= r_idx[W-1:0];
                    r_dl_b[0] <= r_idx[c_PW-1:W];
                    r_dl_v[0] <= w_issue;
                    for (int i = 1; i < LAT; i++) begin
                        r_dl_a[i] <= r_dl_a[i-1];
                        r_dl_b[i] <= r_dl_b[i-1];
                        r_dl_v[i] <= r_dl_v[i-1];
                    end
                end
            end

            assign w_dl_a = r_dl_a[LAT-1];
            assign w_dl_b = r_dl_b[LAT-1];
            assign w_dl_v = r_dl_v[LAT-1];
        end
    endgenerate

    mult_err_stage #(
        .W (W)
    ) u_err_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (w_flush),
        .in_valid  (w_dl_v),
        .a         (w_dl_a),
        .b         (w_dl_b),
        .prod      (prod_in),
        .out_valid (w_c_valid),
        .out_a     (w_c_a),
        .out_b     (w_c_b),
        .abs_err   (w_c_abs)
    );

    assign w_c_mism = (w_c_abs != '0);

    // Stage S: the abort cycle itself contributes nothing, so aborted stats stay as seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count       <= '0;
            max_err         <= '0;
            sum_err         <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
        end else if (w_start_go) begin
            err_count       <= '0;
            max_err         <= '0;
            sum_err         <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
        end else if (w_c_valid && !abort) begin
            err_count <= err_count + {{c_PW{1'b0}}, w_c_mism};
            sum_err   <= sum_err + {{c_PW{1'b0}}, w_c_abs};
            if (w_c_abs > max_err) max_err <= w_c_abs;
            if (w_c_mism && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_a     <= w_c_a;
                first_err_b     <= w_c_b;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_sweep_checker
// Brief    : Directed sweeps of three checker instances against a sweep-level model.
// Revision : 1.0
// ============================================================================
module tb_mult_sweep_checker;

    typedef struct packed {
        longint ec;
        longint me;
        longint se;
        longint fv;
        longint fa;
        longint fb;
    } stats_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_v [3];
    logic abort_v [3];
    int   mode_v  [3];          // 0: exact, 1: (A*B)|1, 2: constant 0

    int n_checks = 0;
    int n_pass   = 0;

    // instance geometry: u0 W=4 LAT=0, u1 W=2 LAT=0, u2 W=4 LAT=2
    int w_of   [3] = '{4, 2, 4};
    int lat_of [3] = '{0, 0, 2};
    int n_of   [3] = '{256, 16, 256};

    logic [3:0] a0, b0, fa0, fb0;  logic [7:0] p0, me0;  logic [8:0] ec0;  logic [15:0] se0;
    logic       busy0, done0, fv0;
    logic [1:0] a1, b1, fa1, fb1;  logic [3:0] p1, me1;  logic [4:0] ec1;  logic [7:0]  se1;
    logic       busy1, done1, fv1;
    logic [3:0] a2, b2, fa2, fb2;  logic [7:0] p2, me2;  logic [8:0] ec2;  logic [15:0] se2;
    logic       busy2, done2, fv2;
    logic [7:0] p2_s1, p2_s2;

    function automatic longint model_p(input int mode, input longint a, input longint b, input int w);
        longint mask;
        mask = (longint'(1) << (2 * w)) - 1;
        case (mode)
            0:       return (a * b) & mask;
            1:       return ((a * b) | 1) & mask;
            default: return 0;
        endcase
    endfunction

    always_comb p0 = 8'(model_p(mode_v[0], longint'(a0), longint'(b0), 4));
    always_comb p1 = 4'(model_p(mode_v[1], longint'(a1), longint'(b1), 2));
    always @(posedge clk) begin
        p2_s1 <= 8'(model_p(mode_v[2], longint'(a2), longint'(b2), 4));
        p2_s2 <= p2_s1;
    end
    assign p2 = p2_s2;

    mult_sweep_checker #(.W(4), .LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .op_a(a0), .op_b(b0), .prod_in(p0), .busy(busy0), .done(done0),
        .err_count(ec0), .max_err(me0), .sum_err(se0),
        .first_err_valid(fv0), .first_err_a(fa0), .first_err_b(fb0));

    mult_sweep_checker #(.W(2), .LAT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .op_a(a1), .op_b(b1), .prod_in(p1), .busy(busy1), .done(done1),
        .err_count(ec1), .max_err(me1), .sum_err(se1),
        .first_err_valid(fv1), .first_err_a(fa1), .first_err_b(fb1));

    mult_sweep_checker #(.W(4), .LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]),
        .op_a(a2), .op_b(b2), .prod_in(p2), .busy(busy2), .done(done2),
        .err_count(ec2), .max_err(me2), .sum_err(se2),
        .first_err_valid(fv2), .first_err_a(fa2), .first_err_b(fb2));

    // Sweep-level model: edges since the accepted start, and the vector count folded into stats.
    bit m_active    [3];
    int m_t         [3];
    int m_idle_vecs [3];
    int m_mode      [3];

    function automatic bit m_busy(input int i);
        return m_active[i] && (m_t[i] < n_of[i] + lat_of[i] + 2);
    endfunction

    function automatic int exp_vecs(input int i);
        int v;
        if (!m_active[i]) return m_idle_vecs[i];
        v = m_t[i] - lat_of[i] - 1;
        if (v < 0) v = 0;
        if (v > n_of[i]) v = n_of[i];
        return v;
    endfunction

    function automatic stats_t sweep_stats(input int mode, input int w, input int cnt);
        stats_t s;
        longint a, b, p, e;
        s = '0;
        for (int k = 0; k < cnt; k++) begin
            a = longint'(k % (1 << w));
            b = longint'(k / (1 << w));
            p = model_p(mode, a, b, w);
            e = (p >= a * b) ? (p - a * b) : (a * b - p);
            if (e != 0) begin
                if (s.fv == 0) begin
                    s.fv = 1;
                    s.fa = a;
                    s.fb = b;
                end
                s.ec = s.ec + 1;
                s.se = s.se + e;
                if (e > s.me) s.me = e;
            end
        end
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_active[i]    <= 1'b0;
                m_t[i]         <= 0;
                m_idle_vecs[i] <= 0;
                m_mode[i]      <= 0;
            end else if (abort_v[i] && m_busy(i)) begin
                m_active[i]    <= 1'b0;
                m_idle_vecs[i] <= exp_vecs(i);
            end else if (start_v[i] && !abort_v[i] && !m_busy(i)) begin
                m_active[i] <= 1'b1;
                m_t[i]      <= 0;
                m_mode[i]   <= mode_v[i];
            end else if (m_active[i]) begin
                m_t[i] <= m_t[i] + 1;
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic cmp_inst(input int i, input longint busy, input longint done,
                            input longint opa, input longint opb, input longint ec,
                            input longint me, input longint se, input longint fv,
                            input longint fa, input longint fb);
        stats_t s;
        longint eb, ed, ea, eo;
        int     tot;
        tot = n_of[i] + lat_of[i] + 2;
        eb  = longint'(m_active[i] && m_t[i] < tot);
        ed  = longint'(m_active[i] && m_t[i] >= tot);
        ea  = 0;
        eo  = 0;
        if (m_active[i] && m_t[i] < n_of[i]) begin
            ea = longint'(m_t[i] % (1 << w_of[i]));
            eo = longint'(m_t[i] / (1 << w_of[i]));
        end
        s = sweep_stats(m_mode[i], w_of[i], exp_vecs(i));
        chk($sformatf("u%0d.busy", i), busy, eb);
        chk($sformatf("u%0d.done", i), done, ed);
        chk($sformatf("u%0d.op_a", i), opa, ea);
        chk($sformatf("u%0d.op_b", i), opb, eo);
        chk($sformatf("u%0d.err_count", i), ec, s.ec);
        chk($sformatf("u%0d.max_err", i), me, s.me);
        chk($sformatf("u%0d.sum_err", i), se, s.se);
        chk($sformatf("u%0d.first_err_valid", i), fv, s.fv);
        chk($sformatf("u%0d.first_err_a", i), fa, s.fa);
        chk($sformatf("u%0d.first_err_b", i), fb, s.fb);
    endtask

    always @(negedge clk) begin
        cmp_inst(0, busy0, done0, a0, b0, ec0, me0, se0, fv0, fa0, fb0);
        cmp_inst(1, busy1, done1, a1, b1, ec1, me1, se1, fv1, fa1, fb1);
        cmp_inst(2, busy2, done2, a2, b2, ec2, me2, se2, fv2, fa2, fb2);
    end

    function automatic logic done_of(input int i);
        case (i)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    task automatic start_pulse(input int i);
        @(negedge clk);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    // Counts edges from the start edge until done is seen; a timeout shows as a wrong count.
    task automatic wait_done(input int i, input int exp_edges, input string nm);
        int edges;
        edges = 0;
        while (!done_of(i) && edges < exp_edges + 20) begin
            @(negedge clk);
            edges++;
        end
        chk({nm, ".latency"}, edges, exp_edges);
    endtask

    task automatic chk_u0(input string nm, input longint ec, input longint me, input longint se,
                          input longint fv, input longint fa, input longint fb);
        chk({nm, ".err_count"}, ec0, ec);
        chk({nm, ".max_err"}, me0, me);
        chk({nm, ".sum_err"}, se0, se);
        chk({nm, ".first_err_valid"}, fv0, fv);
        chk({nm, ".first_err_a"}, fa0, fa);
        chk({nm, ".first_err_b"}, fb0, fb);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            abort_v[i] = 1'b0;
        end
        mode_v[0] = 0;
        mode_v[1] = 2;
        mode_v[2] = 0;
        repeat (3) @(negedge clk);
        chk("rst.busy0", busy0, 0);
        chk("rst.done0", done0, 0);
        chk("rst.op_a0", a0, 0);
        chk("rst.err_count2", ec2, 0);
        rst_n = 1'b1;

        // exact multiplier
        start_pulse(0);
        wait_done(0, 258, "u0.exact");
        chk_u0("u0.exact", 0, 0, 0, 0, 0, 0);

        // (A*B)|1: every even product is off by one
        mode_v[0] = 1;
        start_pulse(0);
        wait_done(0, 258, "u0.or1");
        chk_u0("u0.or1", 192, 1, 192, 1, 0, 0);

        // W=2, constant zero product
        start_pulse(1);
        wait_done(1, 18, "u1.zero");
        chk("u1.zero.err_count", ec1, 9);
        chk("u1.zero.max_err", me1, 9);
        chk("u1.zero.sum_err", se1, 36);
        chk("u1.zero.first_err_a", fa1, 1);
        chk("u1.zero.first_err_b", fb1, 1);

        // two-stage registered multiplier, exact then zero
        start_pulse(2);
        wait_done(2, 260, "u2.exact");
        chk("u2.exact.err_count", ec2, 0);
        chk("u2.exact.sum_err", se2, 0);
        mode_v[2] = 2;
        start_pulse(2);
        wait_done(2, 260, "u2.zero");
        chk("u2.zero.err_count", ec2, 225);
        chk("u2.zero.max_err", me2, 225);
        chk("u2.zero.sum_err", se2, 14400);
        chk("u2.zero.first_err_a", fa2, 1);
        chk("u2.zero.first_err_b", fb2, 1);

        // abort at edge 100: vectors 0..97 are folded in
        mode_v[0] = 2;
        start_pulse(0);
        repeat (99) @(negedge clk);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        chk("u0.abort.busy", busy0, 0);
        chk("u0.abort.done", done0, 0);
        chk_u0("u0.abort", 76, 75, 1806, 1, 1, 1);
        repeat (5) @(negedge clk);
        chk("u0.abort.frozen_sum", se0, 1806);
        start_pulse(0);
        chk("u0.restart.cleared", ec0, 0);
        wait_done(0, 258, "u0.restart");
        chk_u0("u0.restart", 225, 225, 14400, 1, 1, 1);

        // start pulsed at edge 50 while busy is ignored
        start_pulse(0);
        repeat (49) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 208, "u0.midstart");
        chk_u0("u0.midstart", 225, 225, 14400, 1, 1, 1);

        // asynchronous reset in the middle of a sweep
        start_pulse(0);
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.busy", busy0, 0);
        chk("rstmid.op_a", a0, 0);
        chk("rstmid.op_b", b0, 0);
        chk_u0("rstmid", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mode_v[0] = 1;
        start_pulse(0);
        wait_done(0, 258, "u0.after_rst");
        chk_u0("u0.after_rst", 192, 1, 192, 1, 0, 0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
